// File: rtl/vec_gather.sv
// vec_gather: ingress stage for the vector-tile register-file coordinator.
// Collects scalar words from the network over a valid/ready link into a
// lane vector (num_inputs+1 lanes, lane 0 = first word). It then runs the
// write_en / write_rdy / write_ack handshake that commits the vector.
// The network link is back-pressured while a vector is being committed.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   in_valid/ready  network word handshake (in_ready is combinational)
//   in_data/in_last network word; in_last zero-fills the remaining lanes
//   write_en        registered write request, held until write_ack
//   write_rdy       coordinator can take a write
//   write_ack       regfile write complete
//   w_data_out      assembled vector, driven straight from the lane registers
//   busy            not idle (state != FILL or lane index != 0)
//   ack_timeout     sticky abort flag
//
// Optional feature (macro VEC_GATHER_ACK_TIMEOUT_EN): aborts a write that sees
// no write_ack for timeout_cycles WRITE cycles and sets ack_timeout. Without
// the macro, ack_timeout is constant 0 and WRITE waits forever for write_ack.
module vec_gather #(
  parameter int unsigned width          = 16,
  parameter int unsigned num_inputs     = 8,
  parameter int unsigned timeout_cycles = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [width-1:0]                in_data,
  input  logic                            in_last,
  output logic                            write_en,
  input  logic                            write_rdy,
  output logic [num_inputs:0][width-1:0]  w_data_out,
  input  logic                            write_ack,
  output logic                            busy,
  output logic                            ack_timeout
);

  localparam int unsigned LANES = num_inputs + 1;
  localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  typedef enum logic [1:0] {
    S_FILL,
    S_WAIT_RDY,
    S_WRITE,
    S_RELEASE
  } state_e;

  state_e                         state_q;
  logic [IDX_W-1:0]               idx_q;
  logic [num_inputs:0][width-1:0] lane_q;
  logic                           write_en_q;
  logic                           busy_q;
  logic                           ack_timeout_q;
  logic                           accept;
  logic                           tmo_hit;

  // Words are only taken while filling and never during reset.
  assign in_ready = (state_q == S_FILL) && !reset;
  assign accept   = in_valid && in_ready;

  assign write_en    = write_en_q;
  assign busy        = busy_q;
  assign ack_timeout = ack_timeout_q;
  assign w_data_out  = lane_q;

`ifdef VEC_GATHER_ACK_TIMEOUT_EN
  localparam int unsigned TMO_W = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(timeout_cycles - 1);

  logic [TMO_W-1:0] tmo_cnt_q;

  assign tmo_hit = (tmo_cnt_q == TMO_LAST);

  // WRITE-cycle counter; held at zero outside WRITE so every entry starts at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q <= '0;
    end else if (state_q != S_WRITE) begin
      tmo_cnt_q <= '0;
    end else if (!write_ack && !tmo_hit) begin
      tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
    end
  end
`else
  logic unused_tmo;

  assign tmo_hit    = 1'b0;
  assign unused_tmo = ^32'(timeout_cycles);
`endif

  // Main control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_FILL;
      idx_q         <= '0;
      lane_q        <= '0;
      write_en_q    <= 1'b0;
      busy_q        <= 1'b0;
      ack_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        S_FILL: begin
          if (accept) begin
            lane_q[idx_q] <= in_data;
            busy_q        <= 1'b1;
            if (idx_q == LAST_IDX || in_last) begin
              // Short vector: lanes beyond the last word read as zero.
              for (int unsigned i = 0; i < LANES; i++) begin
                if (IDX_W'(i) > idx_q) begin
                  lane_q[IDX_W'(i)] <= '0;
                end
              end
              idx_q   <= '0;
              state_q <= S_WAIT_RDY;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end

        S_WAIT_RDY: begin
          if (write_rdy) begin
            write_en_q <= 1'b1;
            state_q    <= S_WRITE;
          end
        end

        S_WRITE: begin
          // A write_ack on the terminal count takes priority over the abort.
          if (write_ack) begin
            write_en_q <= 1'b0;
            state_q    <= S_RELEASE;
          end else if (tmo_hit) begin
            write_en_q    <= 1'b0;
            ack_timeout_q <= 1'b1;
            state_q       <= S_RELEASE;
          end
        end

        S_RELEASE: begin
          // One idle cycle lets the coordinator drop write_ack.
          lane_q  <= '0;
          busy_q  <= 1'b0;
          state_q <= S_FILL;
        end

        default: begin
          state_q <= S_FILL;
        end
      endcase
    end
  end

endmodule
